// File: rtl/mem_arbiter_if.sv
// Bundles the ifetch, data and shared-memory signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if;
  logic         ifetch_read;
  logic [11:0]  ifetch_address;
  logic [127:0] ifetch_rdata;
  logic         ifetch_resp;

  logic         d_read;
  logic         d_write;
  logic [11:0]  d_address;
  logic [127:0] d_wdata;
  logic [15:0]  d_sel;
  logic [127:0] d_rdata;
  logic         d_resp;

  logic         pmem_read;
  logic         pmem_write;
  logic [11:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [15:0]  pmem_sel;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  ifetch_read, ifetch_address,
    input  d_read, d_write, d_address, d_wdata, d_sel,
    input  pmem_rdata, pmem_resp,
    output ifetch_rdata, ifetch_resp,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_sel
  );

  modport master (
    output ifetch_read, ifetch_address,
    output d_read, d_write, d_address, d_wdata, d_sel,
    output pmem_rdata, pmem_resp,
    input  ifetch_rdata, ifetch_resp,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_sel
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data line requests onto one shared memory port.
// Data normally wins collisions; ifetch is forced after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [2:0]   starve_cnt;

  // Transaction latches: the only source of the pmem request outputs.
  logic [11:0]  lat_addr;
  logic [127:0] lat_wdata;
  logic [15:0]  lat_sel;
  logic         lat_write;

  logic [127:0] i_line;
  logic [127:0] d_line;

  logic         data_req;
  logic         grant_i;
  logic         grant_d;
  logic         resp_ok;

  assign data_req = bus.d_read | bus.d_write;
  // A response landing in the reset cycle belongs to an abandoned transaction.
  assign resp_ok  = bus.pmem_resp & ~rst;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ifetch_read && (!data_req || starve_cnt == LIMIT)) begin
          grant_i    = 1'b1;
          state_next = IFETCH;
        end else if (data_req) begin
          grant_d    = 1'b1;
          state_next = DATA;
        end
      end
      IFETCH, DATA: begin
        if (bus.pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      // NOTE: the wide data latches and line holders are reset too, so post-reset outputs read as zero rather than stale lines.
      lat_wdata  <= '0;
      lat_sel    <= '0;
      i_line     <= '0;
      d_line     <= '0;
    end else begin
      state <= state_next;

      if (grant_i) begin
        lat_addr   <= bus.ifetch_address;
        lat_wdata  <= '0;
        lat_sel    <= '0;
        lat_write  <= 1'b0;
        starve_cnt <= '0;
      end

      if (grant_d) begin
        lat_addr  <= bus.d_address;
        lat_write <= bus.d_write;
        lat_wdata <= bus.d_write ? bus.d_wdata : '0;
        lat_sel   <= bus.d_write ? bus.d_sel   : '0;
        if (bus.ifetch_read && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 3'd1;
      end

      if (state == IFETCH && bus.pmem_resp) i_line <= bus.pmem_rdata;
      if (state == DATA   && bus.pmem_resp) d_line <= bus.pmem_rdata;
    end
  end

  assign bus.pmem_read    = (state == IFETCH) || (state == DATA && !lat_write);
  assign bus.pmem_write   = (state == DATA) && lat_write;
  assign bus.pmem_address = lat_addr;
  assign bus.pmem_wdata   = lat_wdata;
  assign bus.pmem_sel     = lat_sel;

  assign bus.ifetch_resp  = (state == IFETCH) && resp_ok;
  assign bus.d_resp       = (state == DATA)   && resp_ok;

  // The owner sees the memory line in its response cycle; otherwise the last line is held.
  assign bus.ifetch_rdata = bus.ifetch_resp ? bus.pmem_rdata : i_line;
  assign bus.d_rdata      = bus.d_resp      ? bus.pmem_rdata : d_line;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued as requests are raised,
// a memory model answers strobes, and a negedge monitor pops and checks each transaction.
module tb_mem_arbiter;

  localparam int MEM_LAT = 3;
  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;

  typedef struct {
    logic         is_data;
    logic         write;
    logic [11:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  sel;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  txn_t exp_q[$];

  logic         force_resp = 1'b0;
  logic         mem_auto   = 1'b1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rdata_of(input logic [11:0] a);
    return {4{8'hC3, a, ~a}};
  endfunction

  // Memory model: answers MEM_LAT cycles after the first strobe cycle.
  int mem_cnt = 0;
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = JUNK;
    forever begin
      @(posedge clk);
      #1;
      if (bus.pmem_read || bus.pmem_write) mem_cnt++;
      else mem_cnt = 0;
      if (force_resp || (mem_auto && mem_cnt == MEM_LAT + 1)) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rdata_of(bus.pmem_address);
      end else begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = JUNK;
      end
    end
  end

  // Monitor / scoreboard consumer.
  txn_t         cur;
  logic         active    = 1'b0;
  logic         gap       = 1'b0;
  logic         after_rst = 1'b0;
  logic         strobe;
  logic [127:0] last_i    = '0;
  logic [127:0] last_d    = '0;

  always @(negedge clk) begin
    strobe = bus.pmem_read | bus.pmem_write;
    check("resp_exclusive", bus.ifetch_resp & bus.d_resp, 1'b0);
    if (rst) begin
      check("rst_ifetch_resp", bus.ifetch_resp, 1'b0);
      check("rst_d_resp", bus.d_resp, 1'b0);
      active    = 1'b0;
      gap       = 1'b0;
      after_rst = 1'b1;
      last_i    = '0;
      last_d    = '0;
    end else begin
      if (after_rst) begin
        check("post_rst_strobe", strobe, 1'b0);
        after_rst = 1'b0;
      end
      if (gap) begin
        check("idle_gap", strobe, 1'b0);
        gap = 1'b0;
      end
      if (strobe && !active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 1'b1, 1'b0);
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          check("grant_pmem_read", bus.pmem_read, !cur.write);
          check("grant_pmem_write", bus.pmem_write, cur.write);
          check("grant_address", bus.pmem_address, cur.addr);
          check("grant_sel", bus.pmem_sel, cur.write ? cur.sel : 16'h0000);
          if (cur.write) check("grant_wdata", bus.pmem_wdata, cur.wdata);
        end
      end else if (strobe && active) begin
        check("stable_address", bus.pmem_address, cur.addr);
        check("stable_sel", bus.pmem_sel, cur.write ? cur.sel : 16'h0000);
        if (cur.write) check("stable_wdata", bus.pmem_wdata, cur.wdata);
      end
      if (active && strobe && bus.pmem_resp) begin
        check("ifetch_resp", bus.ifetch_resp, !cur.is_data);
        check("d_resp", bus.d_resp, cur.is_data);
        if (cur.is_data) begin
          check("d_rdata", bus.d_rdata, rdata_of(cur.addr));
          check("ifetch_rdata_hold", bus.ifetch_rdata, last_i);
          last_d = rdata_of(cur.addr);
        end else begin
          check("ifetch_rdata", bus.ifetch_rdata, rdata_of(cur.addr));
          check("d_rdata_hold", bus.d_rdata, last_d);
          last_i = rdata_of(cur.addr);
        end
        active = 1'b0;
        gap    = 1'b1;
        done_cnt++;
      end else begin
        check("quiet_ifetch_resp", bus.ifetch_resp, 1'b0);
        check("quiet_d_resp", bus.d_resp, 1'b0);
        check("hold_ifetch_rdata", bus.ifetch_rdata, last_i);
        check("hold_d_rdata", bus.d_rdata, last_d);
      end
    end
  end

  // Returns at posedge+2 once n more transactions have completed.
  task automatic wait_done(input int n);
    int target;
    bit ok;
    target = done_cnt + n;
    ok     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_done_timeout", done_cnt, target);
    #2;
  endtask

  task automatic push(input logic is_data, input logic write, input logic [11:0] addr,
                      input logic [127:0] wdata, input logic [15:0] sel);
    txn_t t;
    t.is_data = is_data;
    t.write   = write;
    t.addr    = addr;
    t.wdata   = wdata;
    t.sel     = sel;
    exp_q.push_back(t);
  endtask

  task automatic clear_reqs();
    bus.ifetch_read = 1'b0;
    bus.d_read      = 1'b0;
    bus.d_write     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0]  a;
    logic [127:0] w;
    logic [15:0]  s;
    int           kind;

    rst = 1'b1;
    clear_reqs();
    bus.ifetch_address = '0;
    bus.d_address      = '0;
    bus.d_wdata        = '0;
    bus.d_sel          = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("reset_state", dut.state, 2'd0);
    check("reset_starve", dut.starve_cnt, 3'd0);
    check("reset_pmem_read", bus.pmem_read, 1'b0);
    check("reset_pmem_write", bus.pmem_write, 1'b0);
    check("reset_ifetch_rdata", bus.ifetch_rdata, 128'h0);
    check("reset_d_rdata", bus.d_rdata, 128'h0);

    // Solo ifetch.
    @(posedge clk); #2;
    push(1'b0, 1'b0, 12'h010, '0, '0);
    bus.ifetch_address = 12'h010;
    bus.ifetch_read    = 1'b1;
    wait_done(1);
    bus.ifetch_read = 1'b0;

    // Collision: data first, then ifetch after one idle cycle.
    @(posedge clk); #2;
    push(1'b1, 1'b0, 12'h0A5, '0, '0);
    push(1'b0, 1'b0, 12'h3F0, '0, '0);
    bus.d_address      = 12'h0A5;
    bus.d_sel          = 16'hFFFF;
    bus.ifetch_address = 12'h3F0;
    bus.d_read         = 1'b1;
    bus.ifetch_read    = 1'b1;
    wait_done(1);
    bus.d_read = 1'b0;
    wait_done(1);
    bus.ifetch_read = 1'b0;
    check("collision_starve", dut.starve_cnt, 3'd0);

    // Starvation: four data grants, then ifetch is forced.
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 12'h200, '0, '0);
    push(1'b0, 1'b0, 12'h111, '0, '0);
    bus.d_address      = 12'h200;
    bus.ifetch_address = 12'h111;
    bus.d_read         = 1'b1;
    bus.ifetch_read    = 1'b1;
    wait_done(4);
    check("starve_at_limit", dut.starve_cnt, 3'd4);
    wait_done(1);
    clear_reqs();
    check("starve_cleared", dut.starve_cnt, 3'd0);

    // Write with inputs changing one cycle after grant.
    @(posedge clk); #2;
    push(1'b1, 1'b1, 12'h3C0, 128'hAB, 16'h0003);
    bus.d_address = 12'h3C0;
    bus.d_wdata   = 128'hAB;
    bus.d_sel     = 16'h0003;
    bus.d_write   = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    bus.d_address = 12'h123;
    bus.d_wdata   = 128'hFF;
    bus.d_sel     = 16'hFFFF;
    wait_done(1);
    clear_reqs();

    // Read and write together count as a write.
    @(posedge clk); #2;
    push(1'b1, 1'b1, 12'h055, 128'h1234_5678, 16'hF0F0);
    bus.d_address = 12'h055;
    bus.d_wdata   = 128'h1234_5678;
    bus.d_sel     = 16'hF0F0;
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    wait_done(1);
    clear_reqs();

    // Mixed single-requester traffic.
    for (int i = 0; i < 6; i++) begin
      kind = int'($urandom_range(0, 2));
      a    = 12'($urandom_range(0, 4095));
      w    = {$urandom, $urandom, $urandom, $urandom};
      s    = 16'($urandom);
      @(posedge clk); #2;
      if (kind == 0) begin
        push(1'b0, 1'b0, a, '0, '0);
        bus.ifetch_address = a;
        bus.ifetch_read    = 1'b1;
      end else begin
        push(1'b1, kind == 2, a, w, s);
        bus.d_address = a;
        bus.d_wdata   = w;
        bus.d_sel     = s;
        bus.d_read    = (kind == 1);
        bus.d_write   = (kind == 2);
      end
      wait_done(1);
      clear_reqs();
    end

    // Spurious response while idle.
    @(posedge clk); #2;
    force_resp = 1'b1;
    @(posedge clk); #2;
    force_resp = 1'b0;
    @(negedge clk);
    check("spurious_ifetch_resp", bus.ifetch_resp, 1'b0);
    check("spurious_d_resp", bus.d_resp, 1'b0);
    check("spurious_state", dut.state, 2'd0);
    @(negedge clk);
    check("spurious_state_after", dut.state, 2'd0);

    // Reset in the same cycle as pmem_resp while serving data.
    @(posedge clk); #2;
    mem_auto = 1'b0;
    push(1'b1, 1'b0, 12'h2A1, '0, '0);
    bus.d_address = 12'h2A1;
    bus.d_read    = 1'b1;
    @(posedge clk); #2;
    check("midop_state_data", dut.state, 2'd2);
    force_resp = 1'b1;
    @(posedge clk); #2;
    rst        = 1'b1;
    force_resp = 1'b0;
    clear_reqs();
    @(negedge clk);
    check("midop_no_d_resp", bus.d_resp, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("midop_pmem_read", bus.pmem_read, 1'b0);
    check("midop_pmem_write", bus.pmem_write, 1'b0);
    check("midop_state_idle", dut.state, 2'd0);
    check("midop_d_rdata", bus.d_rdata, 128'h0);
    mem_auto = 1'b1;

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
